// File: rtl/ace_snoop_cr_collector.sv
`default_nettype none
// ============================================================================
// Module   : ace_snoop_cr_collector
// Purpose  : Gathers one CR beat from every snooped port of a snoop transaction
//            and merges them into a single response plus a data-carrying mask.
// Revision : 1.0
// ============================================================================
module ace_snoop_cr_collector #(
    parameter int NO_SNOOP_PORTS = 4,
    parameter int CR_RESP_WIDTH  = 5
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    start_valid_i,
    output logic                                    start_ready_o,
    input  logic [NO_SNOOP_PORTS-1:0]               start_mask_i,
    input  logic [NO_SNOOP_PORTS-1:0]               cr_valid_i,
    output logic [NO_SNOOP_PORTS-1:0]               cr_ready_o,
    input  logic [NO_SNOOP_PORTS*CR_RESP_WIDTH-1:0] cr_resp_i,
    output logic                                    done_valid_o,
    input  logic                                    done_ready_i,
    output logic [CR_RESP_WIDTH-1:0]                merged_resp_o,
    output logic [NO_SNOOP_PORTS-1:0]               data_mask_o,
    output logic                                    busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NO_SNOOP_PORTS-1:0]   r_pending;
    logic [NO_SNOOP_PORTS-1:0]   w_pending_nxt;
    logic [NO_SNOOP_PORTS-1:0]   r_dmask;
    logic [NO_SNOOP_PORTS-1:0]   w_dmask_nxt;
    logic [NO_SNOOP_PORTS-1:0]   w_hs;
    logic [CR_RESP_WIDTH-1:0]    r_acc;
    logic [CR_RESP_WIDTH-1:0]    w_acc_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_acc     <= '0;
            r_dmask   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_acc     <= w_acc_nxt;
            r_dmask   <= w_dmask_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_acc_nxt     = r_acc;
        w_dmask_nxt   = r_dmask;
        w_hs          = '0;
        start_ready_o = 1'b0;
        cr_ready_o    = '0;
        done_valid_o  = 1'b0;
        merged_resp_o = '0;
        data_mask_o   = '0;

        case (r_state)
            ST_IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    w_pending_nxt = start_mask_i;
                    w_acc_nxt     = '0;
                    w_dmask_nxt   = '0;
                    // An empty mask has nothing to wait for.
                    w_state_nxt   = (start_mask_i != '0) ? ST_COLLECT : ST_DONE;
                end
            end

            ST_COLLECT: begin
                // Ready only toward ports still owed a beat; stray CRs stay parked.
                cr_ready_o = r_pending;
                w_hs       = r_pending & cr_valid_i;
                for (int i = 0; i < NO_SNOOP_PORTS; i++) begin
                    if (w_hs[i]) begin
                        w_acc_nxt      = w_acc_nxt | cr_resp_i[i*CR_RESP_WIDTH +: CR_RESP_WIDTH];
                        w_dmask_nxt[i] = cr_resp_i[i*CR_RESP_WIDTH];
                    end
                end
                w_pending_nxt = r_pending & ~w_hs;
                if (w_pending_nxt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                done_valid_o  = 1'b1;
                merged_resp_o = r_acc;
                data_mask_o   = r_dmask;
                if (done_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (r_state != ST_IDLE);

endmodule
`default_nettype wire
